// File: rtl/twiddle_gen_pkg.sv
// Shared types and sizing helpers for the runtime twiddle-factor generator.
// The sequencer and the bit-serial multiplier both import this package.
package twiddle_gen_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_ADDR_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    MUL   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // The multiplier consumes one multiplier bit per cycle, so its latency equals the data width.
  function automatic int mul_cycles(input int data_width);
    return data_width;
  endfunction

  function automatic int cnt_bits(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mod_mul_seq.sv
// Bit-serial interleaved modular multiplier: res = a*b mod q, scanning b MSB first.
// Fixed MUL_CYCLES latency after go; rdy pulses in the final cycle with res valid combinationally.
module mod_mul_seq
  import twiddle_gen_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] q,
  output logic [DATA_WIDTH-1:0] res,
  output logic                  rdy
);

  localparam int MUL_CYCLES = mul_cycles(DATA_WIDTH);
  localparam int CW         = cnt_bits(MUL_CYCLES);

  logic [DATA_WIDTH:0]   acc;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] q_q;
  logic [CW-1:0]         cnt;

  logic [DATA_WIDTH:0]   a_ext;
  logic [DATA_WIDTH:0]   q_ext;
  logic [DATA_WIDTH:0]   dbl;
  logic [DATA_WIDTH:0]   red1;
  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH:0]   nxt;

  // One interleaved step; the extra accumulator bit keeps 2r and r+a exact since r, a < q.
  always_comb begin
    a_ext = {1'b0, a_q};
    q_ext = {1'b0, q_q};
    dbl   = acc << 1;
    red1  = (dbl >= q_ext) ? (dbl - q_ext) : dbl;
    sum   = b_q[DATA_WIDTH-1] ? (red1 + a_ext) : red1;
    nxt   = (sum >= q_ext) ? (sum - q_ext) : sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      a_q <= '0;
      b_q <= '0;
      q_q <= '0;
      cnt <= '0;
    end else if (go) begin
      acc <= '0;
      a_q <= a;
      b_q <= b;
      q_q <= q;
      cnt <= CW'(MUL_CYCLES);
    end else if (cnt != '0) begin
      acc <= nxt;
      b_q <= b_q << 1;
      cnt <= cnt - 1'b1;
    end
  end

  assign res = nxt[DATA_WIDTH-1:0];
  assign rdy = (cnt == CW'(1));

endmodule

// File: rtl/twiddle_gen.sv
// Runtime twiddle generator: writes omega^i mod q for i = 0..count-1 into the twiddle RAM.
// Holds the sequencing FSM, index/current-power registers and the RAM write port.
module twiddle_gen
  import twiddle_gen_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] omega,
  input  logic [DATA_WIDTH-1:0] modulus,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data
);

  localparam logic [ADDR_WIDTH:0] MAX_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                state;
  state_t                nstate;
  logic [DATA_WIDTH-1:0] omega_q;
  logic [DATA_WIDTH-1:0] q_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH-1:0] idx;
  logic [DATA_WIDTH-1:0] cur;
  logic                  err_q;

  logic                  params_ok;
  logic                  accept;
  logic                  last;
  logic                  mul_go;
  logic [DATA_WIDTH-1:0] mul_res;
  logic                  mul_rdy;

  assign params_ok = (modulus >= DATA_WIDTH'(2)) && (omega < modulus) &&
                     (count != '0) && (count <= MAX_COUNT);
  assign accept    = (state == IDLE) && start && params_ok;
  assign last      = ({1'b0, idx} == (count_q - 1'b1));
  assign mul_go    = (state == WRITE) && !last;

  mod_mul_seq #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mul (
    .clk (clk),
    .rst (rst),
    .go  (mul_go),
    .a   (cur),
    .b   (omega_q),
    .q   (q_q),
    .res (mul_res),
    .rdy (mul_rdy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:  if (accept) nstate = WRITE;
      WRITE: nstate = last ? DONE : MUL;
      MUL:   if (mul_rdy) nstate = WRITE;
      DONE:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Parameters are latched only on an accepted start; a start seen while busy changes nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      omega_q <= '0;
      q_q     <= '0;
      count_q <= '0;
      idx     <= '0;
      cur     <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= (state == IDLE) && start && !params_ok;
      if (accept) begin
        omega_q <= omega;
        q_q     <= modulus;
        count_q <= count;
        cur     <= DATA_WIDTH'(1);
        idx     <= '0;
      end else if ((state == MUL) && mul_rdy) begin
        cur <= mul_res;
        idx <= idx + 1'b1;
      end
    end
  end

  always_comb begin
    busy    = (state != IDLE);
    done    = (state == DONE);
    wr_en   = (state == WRITE);
    err     = err_q;
    wr_addr = idx;
    wr_data = cur;
  end

endmodule

// File: tb/tb_twiddle_gen.sv
// Directed bench for twiddle_gen: vector table of runs/rejects plus reset and full-depth sequences.
module tb_twiddle_gen;
  import twiddle_gen_pkg::*;

  localparam int DW   = 64;
  localparam int AW   = 12;
  localparam int STEP = DW + 1;
  localparam int SDW  = 16;
  localparam int SAW  = 10;
  localparam int SSTEP = SDW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] omega = '0;
  logic [DW-1:0] modulus = '0;
  logic [AW:0]   count = '0;
  logic          busy, done, err, wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  logic           s_start = 1'b0;
  logic [SDW-1:0] s_omega = '0;
  logic [SDW-1:0] s_modulus = '0;
  logic [SAW:0]   s_count = '0;
  logic           s_busy, s_done, s_err, s_wr_en;
  logic [SAW-1:0] s_wr_addr;
  logic [SDW-1:0] s_wr_data;

  int checks = 0;
  int fails  = 0;

  twiddle_gen #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .omega(omega), .modulus(modulus), .count(count),
    .busy(busy), .done(done), .err(err), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // Narrow instance so a full-depth table finishes in a short run.
  twiddle_gen #(.DATA_WIDTH(SDW), .ADDR_WIDTH(SAW)) dut_small (
    .clk(clk), .rst(rst), .start(s_start), .omega(s_omega), .modulus(s_modulus), .count(s_count),
    .busy(s_busy), .done(s_done), .err(s_err), .wr_en(s_wr_en), .wr_addr(s_wr_addr),
    .wr_data(s_wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    string          name;
    logic [DW-1:0]  omega;
    logic [DW-1:0]  q;
    logic [AW:0]    count;
    bit             reject;
    int             poke_n;
    logic [3:0][DW-1:0] exp;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input string name, input logic [DW-1:0] om, input logic [DW-1:0] q,
                              input logic [AW:0] cnt, input bit rej, input int poke,
                              input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                              input logic [DW-1:0] e2, input logic [DW-1:0] e3);
    vec_t v;
    v.name = name; v.omega = om; v.q = q; v.count = cnt; v.reject = rej; v.poke_n = poke;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [DW-1:0] om, input logic [DW-1:0] q,
                                input logic [AW:0] cnt);
    @(negedge clk);
    omega = om; modulus = q; count = cnt; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs one vector; n counts cycles after the accepting edge (n=1 is the first WRITE cycle).
  task automatic run_vector(input vec_t v);
    int done_n, end_n, j;
    logic [DW-1:0]  model;
    logic [127:0]   prod;
    logic [3:0]     exp_ctl;
    bit             exp_wr;
    logic [DW-1:0]  exp_data;
    done_n = 2 + (int'(v.count) - 1) * STEP;
    end_n  = v.reject ? 3 : done_n + 2;
    model  = 1;
    apply_stimulus(v.omega, v.q, v.count);
    for (int n = 1; n <= end_n; n++) begin
      exp_wr  = !v.reject && ((n - 1) % STEP == 0) && ((n - 1) / STEP < int'(v.count));
      exp_ctl = {!v.reject && (n <= done_n), !v.reject && (n == done_n), v.reject && (n == 1), exp_wr};
      check_output($sformatf("%s ctl n=%0d {busy,done,err,wr_en}", v.name, n),
                   {busy, done, err, wr_en}, exp_ctl);
      if (exp_wr) begin
        j = (n - 1) / STEP;
        exp_data = (j < 4) ? v.exp[j] : model;
        check_output($sformatf("%s addr j=%0d", v.name, j), wr_addr, j);
        check_output($sformatf("%s data j=%0d", v.name, j), wr_data, exp_data);
        prod  = {64'b0, model} * {64'b0, v.omega};
        model = DW'(prod % {64'b0, v.q});
      end
      if (n == v.poke_n) begin
        start = 1'b1; omega = 64'd7; modulus = 64'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    vecs[0] = mk("basic",   64'd3, 64'd17, 13'd4, 1'b0, 0,  64'd1, 64'd3, 64'd9, 64'd10);
    vecs[1] = mk("busypoke", 64'd3, 64'd17, 13'd4, 1'b0, 30, 64'd1, 64'd3, 64'd9, 64'd10);
    vecs[2] = mk("count1",  64'd3, 64'd17, 13'd1, 1'b0, 0,  64'd1, 64'd0, 64'd0, 64'd0);
    vecs[3] = mk("widecarry", 64'hFFFFFFFFFFFFFFC4, 64'hFFFFFFFFFFFFFFC5, 13'd4, 1'b0, 0,
                 64'd1, 64'hFFFFFFFFFFFFFFC4, 64'd1, 64'hFFFFFFFFFFFFFFC4);
    vecs[4] = mk("omega0",  64'd0, 64'd17, 13'd3, 1'b0, 0,  64'd1, 64'd0, 64'd0, 64'd0);
    vecs[5] = mk("mod7",    64'd5, 64'd7,  13'd4, 1'b0, 0,  64'd1, 64'd5, 64'd4, 64'd6);
    vecs[6] = mk("rej_omega_eq_q", 64'd17, 64'd17, 13'd4, 1'b1, 0, 0, 0, 0, 0);
    vecs[7] = mk("rej_q1",  64'd0, 64'd1,  13'd4,    1'b1, 0, 0, 0, 0, 0);
    vecs[8] = mk("rej_cnt0", 64'd3, 64'd17, 13'd0,   1'b1, 0, 0, 0, 0, 0);
    vecs[9] = mk("rej_cnt4097", 64'd3, 64'd17, 13'd4097, 1'b1, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    check_output("reset ctl", {busy, done, err, wr_en}, 4'b0);
    check_output("reset addr/data", {wr_addr, wr_data}, '0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_vector(vecs[i]);

    // Reset during the multiply that produces entry 2, then a clean rerun.
    apply_stimulus(64'd3, 64'd17, 13'd4);
    repeat (79) @(negedge clk);
    check_output("pre-reset busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check_output("midreset ctl", {busy, done, err, wr_en}, 4'b0);
    check_output("midreset addr/data", {wr_addr, wr_data}, '0);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check_output($sformatf("in-reset ctl n=%0d", n), {busy, done, err, wr_en}, 4'b0);
    end
    rst = 1'b0;
    run_vector(vecs[0]);

    // Full depth on the narrow instance: every address once, data all 1, done right after the last.
    begin
      int done_n, nwr;
      bit exp_wr;
      done_n = 2 + ((1 << SAW) - 1) * SSTEP;
      nwr = 0;
      @(negedge clk);
      s_omega = 16'd1; s_modulus = 16'd12289; s_count = 11'd1024; s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      for (int n = 1; n <= done_n + 2; n++) begin
        exp_wr = ((n - 1) % SSTEP == 0) && ((n - 1) / SSTEP < (1 << SAW));
        if (s_wr_en !== exp_wr || s_done !== (n == done_n) || s_busy !== (n <= done_n) || s_err !== 1'b0)
          check_output($sformatf("full ctl n=%0d {busy,done,err,wr_en}", n),
                       {s_busy, s_done, s_err, s_wr_en},
                       {n <= done_n, n == done_n, 1'b0, exp_wr});
        if (exp_wr) begin
          check_output($sformatf("full addr %0d", nwr), s_wr_addr, nwr);
          check_output($sformatf("full data %0d", nwr), s_wr_data, 1);
          nwr++;
        end
        @(negedge clk);
      end
      check_output("full write count", nwr, 1 << SAW);
      check_output("full final addr", s_wr_addr, (1 << SAW) - 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/twiddle_gen.md
Name: twiddle_gen

Overview:
Runtime twiddle-factor generator. It computes successive powers of a root of unity, omega^i mod q for i = 0..count-1, and writes them into the NTT twiddle RAM through a simple write port. This lets the NTT accelerator change modulus or ring size without reloading a precomputed hex image. It sits beside the twiddle storage, and the host/control FSM triggers it before NTT runs.

Parameters:
DATA_WIDTH, 64, width of twiddle values, omega and modulus
ADDR_WIDTH, 12, twiddle RAM address width; table depth is 2^ADDR_WIDTH

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to generate a table; sampled only in IDLE
omega  input  DATA_WIDTH  root of unity; sampled with start
modulus  input  DATA_WIDTH  modulus q; sampled with start
count  input  ADDR_WIDTH+1  number of entries to write, 1..2^ADDR_WIDTH; sampled with start
busy  output  1  high while state != IDLE
done  output  1  one-cycle pulse after the final write
err  output  1  one-cycle pulse when start is rejected
wr_en  output  1  RAM write strobe, one cycle per entry
wr_addr  output  ADDR_WIDTH  RAM write address
wr_data  output  DATA_WIDTH  RAM write data

Behaviour:
- Reset: all outputs are 0, state is IDLE, and internal registers are cleared. Reset mid-generation stops all writes immediately. Entries already written are left as they are; table contents are then undefined to the consumer.
- States: IDLE, WRITE, MUL, DONE.
- IDLE, start=1 with valid parameters: latch omega, q and count; set cur=1 and idx=0; go to WRITE.
- Valid parameters require q >= 2, omega < q, and 1 <= count <= 2^ADDR_WIDTH.
- IDLE, start=1 with invalid parameters: err=1 for the next cycle only. Stay in IDLE, with no wr_en and no busy.
- WRITE (one cycle): wr_en=1, wr_addr=idx, wr_data=cur.
  - If idx == count-1, go to DONE.
  - Otherwise launch the multiplication cur*omega mod q and go to MUL.
- MUL: a bit-serial interleaved modular multiply, scanning omega from MSB to LSB, one bit per cycle, for exactly DATA_WIDTH cycles.
  - Each step: r = 2r; if r >= q then r -= q; if the bit is 1, then r += cur and if r >= q then r -= q.
  - The accumulator is DATA_WIDTH+1 bits wide so that 2r and r+cur never overflow.
  - After DATA_WIDTH cycles: cur = r, idx = idx+1, go to WRITE.
- DONE (one cycle): done=1, go to IDLE.
- Timing: with start accepted at edge k, entry j is written in cycle k+1+j*(DATA_WIDTH+1). done is asserted in cycle k+2+(count-1)*(DATA_WIDTH+1).
- busy is high from k+1 through the DONE cycle inclusive. start while busy is ignored: no err, and latched values are unchanged.
- Outside WRITE, wr_en=0. wr_addr/wr_data hold their last value.
- idx never wraps. count = 2^ADDR_WIDTH ends with the write to address 2^ADDR_WIDTH-1.
- omega = 0 is legal: the table is 1, 0, 0, ...
- Input values are ignored after latching, so changes during busy have no effect.

Decomposition:
- Shared package: the state enum (IDLE/WRITE/MUL/DONE) and a MUL_CYCLES = DATA_WIDTH localparam convention.
- Sub-module mod_mul_seq holds the bit-serial multiplier.
  - Inputs: clk, rst, go, a, b, q.
  - Outputs: res, rdy.
  - It has a fixed DATA_WIDTH-cycle latency, and rdy is a one-cycle pulse with res valid.
  - twiddle_gen keeps only the sequencing FSM, idx/cur registers and write port.

Test Plan:
- Basic sequence: q=17, omega=3, count=4, start at k.
  - Writes are (0,1) at k+1, (1,3) at k+66, (2,9) at k+131, (3,10) at k+196.
  - done at k+197; busy spans k+1..k+197.
- Full depth: q=12289, omega=1, count=4096.
  - 4096 writes, addresses 0..4095, all data=1, no wrap.
  - done exactly one cycle after the addr 4095 write.
- Wide carry: q=0xFFFFFFFFFFFFFFC5, omega=q-1, count=4.
  - Data is 1, q-1, 1, q-1, exercising the DATA_WIDTH+1 accumulator.
- Rejects: each of (omega=17, q=17), (q=1), (count=0) and (count=4097) gives an err pulse next cycle, with no wr_en, busy or done.
- Busy/start: assert start with new omega during MUL of the first test.
  - It is ignored: same writes and timing, no err.
  - count=1 gives a single write (0,1) and done at k+2.
- Reset mid-op: assert rst during MUL of entry 2.
  - Outputs go to 0 immediately with no further writes.
  - After release, a new start runs normally from address 0.
